// File: rtl/resta_serial_pkg.sv
// Shared declarations for the bit-serial subtractor.
//   resta_state_t : controller state encoding (IDLE, RUN, DONE)
//   RESTA_M_DEF   : default operand width
//   RESTA_CNT_W   : bit-counter width for the default operand width
//   resta_cnt_w() : bit-counter width for an arbitrary operand width M >= 2
package resta_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } resta_state_t;

    localparam int RESTA_M_DEF = 4;
    localparam int RESTA_CNT_W = $clog2(RESTA_M_DEF);

    // The counter indexes bits 0..M-1, so $clog2(M) bits suffice; M=2 still needs 1 bit.
    function automatic int resta_cnt_w(input int m);
        return (m > 2) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/resta_serial_full_adder.sv
// Single-bit full adder used as the serial bit cell of resta_serial.
//   a, b : operand bits
//   cin  : carry in
//   s    : sum bit
//   cout : carry out (majority of a, b, cin)
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/resta_serial.sv
// Bit-serial two's-complement subtractor R = A - B, one bit per clock, LSB first.
// A - B is formed as A + ~B + 1: B is inverted and the carry preset to 1 when the
// operands are captured, so the single full-adder cell only ever adds.
//   clk    : system clock, rising edge
//   rst_n  : synchronous reset, active-low
//   start  : request, sampled only while idle
//   A, B   : minuend / subtrahend, captured on an accepted start
//   busy   : high while an operation is running or completing
//   done   : one-cycle pulse; R and flags valid from this cycle on
//   R      : A - B mod 2^M
//   C      : carry out (1 = no borrow)
//   N      : sign of R
//   V      : signed overflow
//   Z      : R == 0
module resta_serial
    import resta_pkg::*;
#(
    parameter int M = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [M-1:0] A,
    input  logic [M-1:0] B,
    output logic         busy,
    output logic         done,
    output logic [M-1:0] R,
    output logic         C,
    output logic         N,
    output logic         V,
    output logic         Z
);

    localparam int CW = resta_cnt_w(M);

    resta_state_t  state, state_n;
    logic [CW-1:0] cnt;
    logic [M-1:0]  a_sh, b_sh, r_sh;
    logic          cy;
    logic          sa, sb;

    logic          bit_s, bit_co;
    logic [M-1:0]  r_next;
    logic          last_bit;
    logic          accept;

    full_adder u_cell (
        .a    (a_sh[0]),
        .b    (b_sh[0]),
        .cin  (cy),
        .s    (bit_s),
        .cout (bit_co)
    );

    // Result bits arrive LSB first, so each new sum enters at the top and the
    // register shifts right; after M bits the word is correctly aligned.
    assign r_next   = {bit_s, r_sh[M-1:1]};
    assign last_bit = (cnt == CW'(M - 1));
    assign accept   = (state == IDLE) && start;

    assign busy = (state != IDLE);
    assign done = (state == DONE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (start)    state_n = RUN;
            RUN:     if (last_bit) state_n = DONE;
            DONE:                  state_n = IDLE;
            default:               state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt  <= '0;
            a_sh <= '0;
            b_sh <= '0;
            r_sh <= '0;
            cy   <= 1'b0;
            sa   <= 1'b0;
            sb   <= 1'b0;
            R    <= '0;
            C    <= 1'b0;
            N    <= 1'b0;
            V    <= 1'b0;
            Z    <= 1'b0;
        end else if (accept) begin
            a_sh <= A;
            b_sh <= ~B;
            r_sh <= '0;
            cy   <= 1'b1;
            cnt  <= '0;
            sa   <= A[M-1];
            sb   <= B[M-1];
        end else if (state == RUN) begin
            a_sh <= a_sh >> 1;
            b_sh <= b_sh >> 1;
            r_sh <= r_next;
            cy   <= bit_co;
            cnt  <= cnt + 1'b1;
            // Publish on the final bit using the not-yet-registered result so
            // R and the flags are valid in the same cycle done rises.
            if (last_bit) begin
                R <= r_next;
                C <= bit_co;
                N <= r_next[M-1];
                Z <= (r_next == '0);
                // Overflow only possible when operand signs differ, and then
                // shows as the result sign disagreeing with the minuend.
                V <= (sa != sb) && (r_next[M-1] != sa);
            end
        end
    end

endmodule

// File: tb/tb_resta_serial.sv
module tb_resta_serial;

    localparam int M = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [M-1:0] A = '0;
    logic [M-1:0] B = '0;
    logic         busy, done;
    logic [M-1:0] R;
    logic         C, N, V, Z;

    int checks = 0;
    int failures = 0;
    bit cmp_en = 1'b0;

    resta_serial #(.M(M)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .A     (A),
        .B     (B),
        .busy  (busy),
        .done  (done),
        .R     (R),
        .C     (C),
        .N     (N),
        .V     (V),
        .Z     (Z)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Reference subtraction from plain integer arithmetic.
    function automatic void ref_sub(input int a, input int b, output logic [M-1:0] r,
                                    output logic [3:0] flags);
        int diff, sa, sb, sd;
        logic c, n, v, z;
        diff = a - b;
        r    = M'(diff);
        c    = (a >= b);
        sa   = (a >= (1 << (M - 1))) ? a - (1 << M) : a;
        sb   = (b >= (1 << (M - 1))) ? b - (1 << M) : b;
        sd   = sa - sb;
        v    = (sd > (1 << (M - 1)) - 1) || (sd < -(1 << (M - 1)));
        n    = r[M-1];
        z    = (r == '0);
        flags = {c, n, v, z};
    endfunction

    // Behavioural model: an operation occupies M+1 cycles after acceptance,
    // results appear on its last cycle and persist until the next one completes.
    int           m_left = 0;
    logic [M-1:0] m_r = '0, p_r = '0;
    logic [3:0]   m_f = '0, p_f = '0;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_left = 0;
            m_r    = '0;
            m_f    = '0;
        end else if (m_left == 0) begin
            if (start) begin
                ref_sub(int'(A), int'(B), p_r, p_f);
                m_left = M + 1;
            end
        end else begin
            m_left--;
            if (m_left == 1) begin
                m_r = p_r;
                m_f = p_f;
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("busy", 32'(busy), 32'(m_left != 0));
            chk("done", 32'(done), 32'(m_left == 1));
            chk("R", 32'(R), 32'(m_r));
            chk("flags_CNVZ", 32'({C, N, V, Z}), 32'(m_f));
        end
    end

    task automatic run_op(input string nm, input logic [M-1:0] a, input logic [M-1:0] b,
                          input logic [M-1:0] er, input logic [3:0] ef, input bit inj);
        int lat;
        @(negedge clk);
        start = 1'b1;
        A = a;
        B = b;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            if (lat == 1) begin
                start = 1'b0;
                A = M'($urandom);
                B = M'($urandom);
            end
            if (inj && lat == 2) begin
                start = 1'b1;
                A = ~a;
                B = a;
            end
            if (inj && lat == 3) start = 1'b0;
        end while (!done && lat < 20);
        chk({nm, "_latency"}, 32'(lat), 32'(M + 1));
        chk({nm, "_R"}, 32'(R), 32'(er));
        chk({nm, "_CNVZ"}, 32'({C, N, V, Z}), 32'(ef));
        @(negedge clk);
        chk({nm, "_busy_after_done"}, 32'(busy), 32'd0);
        chk({nm, "_done_pulse"}, 32'(done), 32'd0);
    endtask

    initial begin
        logic [M-1:0] lr;
        logic [3:0]   lf;

        // Pin the model against hand-computed vectors.
        ref_sub(5, 3, lr, lf);
        chk("model_5m3", 32'({lr, lf}), 32'({4'b0010, 4'b1000}));
        ref_sub(7, 15, lr, lf);
        chk("model_7m15", 32'({lr, lf}), 32'({4'b1000, 4'b0110}));
        ref_sub(8, 1, lr, lf);
        chk("model_8m1", 32'({lr, lf}), 32'({4'b0111, 4'b1010}));

        repeat (3) @(negedge clk);
        rst_n  = 1'b1;
        cmp_en = 1'b1;
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_R", 32'({R, C, N, V, Z}), 32'd0);

        run_op("t5m3", 4'b0101, 4'b0011, 4'b0010, 4'b1000, 1'b0);
        run_op("t3m5", 4'b0011, 4'b0101, 4'b1110, 4'b0100, 1'b0);
        run_op("t7m15", 4'b0111, 4'b1111, 4'b1000, 4'b0110, 1'b0);
        run_op("t8m1", 4'b1000, 4'b0001, 4'b0111, 4'b1010, 1'b0);
        run_op("t9m9", 4'b1001, 4'b1001, 4'b0000, 4'b1001, 1'b0);
        run_op("tB0", 4'b0110, 4'b0000, 4'b0110, 4'b1000, 1'b0);
        run_op("inj", 4'b0101, 4'b0011, 4'b0010, 4'b1000, 1'b1);

        // Reset during the second RUN cycle.
        @(negedge clk);
        start = 1'b1; A = 4'b0011; B = 4'b0101;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        chk("midrst_out", 32'({R, C, N, V, Z}), 32'd0);
        rst_n = 1'b1;
        repeat (8) begin
            @(negedge clk);
            chk("midrst_no_done", 32'(done), 32'd0);
        end
        run_op("after_rst", 4'b1100, 4'b0100, 4'b1000, 4'b1100, 1'b0);

        // start held high: back-to-back operations, model checks acceptance timing.
        @(negedge clk);
        start = 1'b1; A = 4'b1010; B = 4'b0111;
        repeat (3 * (M + 2)) @(negedge clk);
        start = 1'b0;
        repeat (M + 3) @(negedge clk);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            start = ($urandom_range(0, 3) != 0);
            A = M'($urandom);
            B = M'($urandom);
            rst_n = ($urandom_range(0, 99) != 0);
        end
        rst_n = 1'b1;
        start = 1'b0;
        repeat (M + 4) @(negedge clk);

        cmp_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
